norm_scheduler: RTL and testbench

Shares one direction-normalization unit (mul → sqrt → divide pipeline, multi-cycle, non-pipelined) among NUM_REQ requesters, for example the primary-ray generator, the light-direction unit and the surface-normal unit. It arbitrates round-robin and captures the winner's direction vector. It pulses start to the unit, waits for its valid, and returns the normalized vector tagged to the winner. It also short-circuits zero vectors, because the unit never asserts valid for them, and bounds every job with a timeout.

---
 rtl/norm_scheduler.sv | 177 +++++++++++++++++
 tb/tb_norm_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/norm_scheduler.sv
// norm_scheduler: round-robin front end that shares one multi-cycle,
// non-pipelined direction-normalization unit among NUM_REQ requesters.
// Zero vectors are answered locally because the unit never completes them.
// Every job in WAIT is bounded by TIMEOUT cycles and ends with an error
// response if the unit does not answer in time.
//
// Handshake summary:
//   req/gnt         : a requester holds req high until it sees its one-cycle
//                     gnt pulse; dir_in is captured on the granting edge.
//   norm_start      : one-cycle pulse, only raised while norm_idle=1; norm_dir
//                     stays stable until the scheduler returns to IDLE.
//   norm_valid      : single-cycle result strobe; only honoured in WAIT.
//   rsp_valid       : one-hot, one-cycle pulse to the job owner; rsp_zero and
//                     rsp_err qualify it and otherwise keep their last value.
module norm_scheduler #(
  parameter int WIDTH   = 32,
  parameter int Q_BITS  = 16,
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*3*WIDTH-1:0] dir_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [3*WIDTH-1:0]         rsp_dir,
  output logic                       rsp_zero,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       norm_start,
  output logic [3*WIDTH-1:0]         norm_dir,
  input  logic                       norm_idle,
  input  logic                       norm_valid,
  input  logic [3*WIDTH-1:0]         norm_result
);

  localparam int VW  = 3 * WIDTH;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [NUM_REQ-1:0] gnt_d, rsp_valid_d;
  logic [VW-1:0]      rsp_dir_d, norm_dir_d;
  logic               rsp_zero_d, rsp_err_d, norm_start_d, busy_d;

  // Round-robin search result
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     win_next;
  logic [IDW-1:0]     scan;

  // Pick the first asserted request at or after ptr, wrapping upward
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
    win_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    timer_d      = timer_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_dir_d    = rsp_dir;
    rsp_zero_d   = rsp_zero;
    rsp_err_d    = rsp_err;
    norm_start_d = 1'b0;
    norm_dir_d   = norm_dir;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          ptr_d      = win_next;
          id_d       = win_idx;
          norm_dir_d = dir_in[win_idx*VW +: VW];
          gnt_d      = NUM_REQ'(1) << win_idx;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (norm_dir == '0) begin
          // Unit would never finish a zero vector: answer it here
          rsp_dir_d   = '0;
          rsp_zero_d  = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << id_q;
          state_d     = S_IDLE;
        end else if (norm_idle) begin
          // Waiting for norm_idle also drains any late result of a timed-out job
          norm_start_d = 1'b1;
          timer_d      = '0;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (norm_valid) begin
          // A result on the timeout edge still counts as success
          rsp_dir_d   = norm_result;
          rsp_zero_d  = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << id_q;
          state_d     = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_dir_d   = '0;
          rsp_zero_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << id_q;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, bookkeeping and output registers; reset discards any job in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      timer_q    <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_dir    <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      norm_start <= 1'b0;
      norm_dir   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      timer_q    <= timer_d;
      gnt        <= gnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_dir    <= rsp_dir_d;
      rsp_zero   <= rsp_zero_d;
      rsp_err    <= rsp_err_d;
      busy       <= busy_d;
      norm_start <= norm_start_d;
      norm_dir   <= norm_dir_d;
    end
  end

endmodule

// File: tb/tb_norm_scheduler.sv
// Directed and randomized bench for norm_scheduler. The normalization unit is
// stubbed inline; expected grants and responses come from a small reference
// model (round-robin pick over a queue-free pointer, latency/timeout rule).
module tb_norm_scheduler;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int TO = 16;
  localparam int VW = 3 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*VW-1:0] dir_in = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [VW-1:0]   rsp_dir, norm_dir;
  logic            rsp_zero, rsp_err, busy, norm_start;
  logic            norm_idle = 1'b1;
  logic            norm_valid = 1'b0;
  logic [VW-1:0]   norm_result = '0;

  norm_scheduler #(
    .WIDTH(W), .Q_BITS(16), .NUM_REQ(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .dir_in(dir_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_dir(rsp_dir),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
    .norm_start(norm_start), .norm_dir(norm_dir),
    .norm_idle(norm_idle), .norm_valid(norm_valid), .norm_result(norm_result)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [VW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin choice: first requester at or after p, with wrap
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    norm_valid = 1'b0;
    norm_idle = 1'b1;
    step();
    step();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // ---------------- driver: one complete job ----------------
  // lat: stub answers on the lat-th WAIT edge (0 or >TO means never in time)
  // hold: cycles norm_idle stays low in ISSUE, with a stale valid on the first
  task automatic do_job(input int lat, input logic [VW-1:0] res, input int hold, input bit keep_req);
    int w;
    int rc;
    bit err_exp;
    logic [VW-1:0] v;
    logic [VW-1:0] onehot;
    w = model_pick(req, ptr_m);
    if (w < 0) begin
      chk("no_request_in_model", VW'(req), VW'(1));
      return;
    end
    v = dir_in[w*VW +: VW];
    ptr_m = (w + 1) % N;
    onehot = VW'(1) << w;
    exp_q.push_back(v);
    step();
    chk("gnt", VW'(gnt), onehot);
    chk("busy_after_gnt", VW'(busy), VW'(1));
    chk("rsp_idle_at_gnt", VW'(rsp_valid), '0);
    if (!keep_req) req[w] = 1'b0;
    if (v == '0) begin
      step();
      chk("zero_rsp_valid", VW'(rsp_valid), onehot);
      chk("zero_rsp_zero", VW'(rsp_zero), VW'(1));
      chk("zero_rsp_err", VW'(rsp_err), '0);
      chk("zero_rsp_dir", rsp_dir, '0);
      chk("zero_no_start", VW'(norm_start), '0);
      chk("zero_busy", VW'(busy), '0);
      void'(exp_q.pop_front());
    end else begin
      if (hold > 0) begin
        norm_idle = 1'b0;
        for (int h = 0; h < hold; h++) begin
          norm_valid = (h == 0);
          norm_result = ~res;
          step();
          norm_valid = 1'b0;
          chk("issue_no_start", VW'(norm_start), '0);
          chk("issue_no_rsp", VW'(rsp_valid), '0);
        end
        norm_idle = 1'b1;
      end
      step();
      chk("norm_start", VW'(norm_start), VW'(1));
      chk("norm_dir", norm_dir, exp_q[0]);
      err_exp = !(lat >= 1 && lat <= TO);
      rc = err_exp ? TO : lat;
      for (int c = 1; c <= rc; c++) begin
        norm_valid = (c == lat);
        norm_result = res;
        step();
        norm_valid = 1'b0;
        if (c == 1) chk("start_one_pulse", VW'(norm_start), '0);
        if (c < rc) chk("no_early_rsp", VW'(rsp_valid), '0);
      end
      chk("rsp_valid", VW'(rsp_valid), onehot);
      chk("rsp_err", VW'(rsp_err), VW'(err_exp));
      chk("rsp_zero", VW'(rsp_zero), '0);
      chk("rsp_dir", rsp_dir, err_exp ? '0 : res);
      chk("busy_after_rsp", VW'(busy), '0);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, VW'(gnt), '0);
    chk({tag, "_rsp_valid"}, VW'(rsp_valid), '0);
    chk({tag, "_rsp_dir"}, rsp_dir, '0);
    chk({tag, "_rsp_flags"}, VW'({rsp_zero, rsp_err}), '0);
    chk({tag, "_busy"}, VW'(busy), '0);
    chk({tag, "_norm_start"}, VW'(norm_start), '0);
    chk({tag, "_norm_dir"}, norm_dir, '0);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    step();
    chk_all_zero("reset");
    do_reset();

    // single request {3.0, 4.0, 0} with 12-cycle unit latency
    dir_in[0 +: VW] = {32'h0003_0000, 32'h0004_0000, 32'h0};
    req = 3'b001;
    do_job(12, {32'h0000_9999, 32'h0000_CCCC, 32'h0}, 0, 1'b0);

    // fairness from reset with all requests held
    do_reset();
    for (int i = 0; i < N; i++) dir_in[i*VW +: VW] = rand_vec() | VW'(1);
    req = 3'b111;
    for (int j = 0; j < 6; j++) do_job(2, rand_vec(), 0, 1'b1);
    req = '0;
    step();

    // zero vector from requester 1
    dir_in[1*VW +: VW] = '0;
    req = 3'b010;
    do_job(5, rand_vec(), 0, 1'b0);

    // timeout, then a stale valid while the next job waits in ISSUE
    dir_in[0 +: VW] = rand_vec() | VW'(1);
    req = 3'b001;
    do_job(0, rand_vec(), 0, 1'b0);
    dir_in[2*VW +: VW] = rand_vec() | VW'(1);
    req = 3'b100;
    do_job(5, rand_vec(), 3, 1'b0);

    // valid exactly on the timeout edge
    dir_in[1*VW +: VW] = rand_vec() | VW'(1);
    req = 3'b010;
    do_job(TO, rand_vec(), 0, 1'b0);

    // reset five cycles into WAIT
    dir_in[0 +: VW] = rand_vec() | VW'(1);
    req = 3'b001;
    step();
    req = '0;
    step();
    chk("mid_start", VW'(norm_start), VW'(1));
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    reset = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < N; i++) dir_in[i*VW +: VW] = rand_vec() | VW'(1);
    req = 3'b111;
    do_job(3, rand_vec(), 0, 1'b0);

    // randomized traffic: mixed vectors, latencies, ISSUE stalls
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          dir_in[i*VW +: VW] = ($urandom_range(0, 4) == 0) ? '0 : rand_vec();
        end
      end
      if (req == '0) begin
        req[0] = 1'b1;
        dir_in[0 +: VW] = rand_vec();
      end
      do_job($urandom_range(1, 20), rand_vec(), $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
